rv_mem_stage: RTL and testbench

- Memory pipeline stage of the rvcpu core: consumes stage_ex_t from execute and produces stage_mem_t for writeback.
- Drives the data-bus initiator handshake: request/grant for the address phase, rvalid for the load response.
- Aligns and extends load data, and generates store byte enables and lane-shifted store data.
- Non-memory results pass through with one registered cycle of latency.

---
 rtl/rvcpu_pkg.sv | 99 +++++++++
 rtl/rv_mem_stage_align.sv | 31 +++
 rtl/rv_mem_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_rv_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_pkg.sv
// rvcpu_pkg: shared types, constants and helper functions for the rvcpu
// memory stage.
//
// Contents:
//   data_t / addr_t       32-bit data and address words
//   mem_op_t              access size/sign code carried in op[2:0]
//   mem_state_t           memory-stage FSM states (IDLE, REQ, WAIT)
//   MEM_STORE_BIT         bit of op that marks a store
//   stage_ex_t            execute -> memory payload (75 bits)
//   stage_mem_t           memory -> writeback payload (38 bits)
//   mem_be / mem_wdata    store byte enables and lane-replicated store data
//   mem_rdata             load lane extraction with sign/zero extension
//   mem_misaligned        natural-alignment test used by the optional trap
package rvcpu_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [XLEN-1:0] addr_t;

    // Codes 010, 110 and 111 are unassigned and behave as a word access.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b011,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    localparam int MEM_STORE_BIT = 3;

    typedef struct packed {
        logic       is_mem;
        logic [3:0] op;
        logic [4:0] rd;
        logic       rd_valid;
        addr_t      addr;
        data_t      data;
    } stage_ex_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       rd_valid;
        data_t      rd_data;
    } stage_mem_t;

    function automatic logic [3:0] mem_be(mem_op_t op, logic [1:0] lane);
        logic [3:0] be;
        case (op)
            MEM_B, MEM_BU: be = 4'b0001 << lane;
            MEM_H, MEM_HU: be = 4'b0011 << {lane[1], 1'b0};
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic data_t mem_wdata(mem_op_t op, data_t d);
        data_t w;
        case (op)
            MEM_B, MEM_BU: w = {4{d[7:0]}};
            MEM_H, MEM_HU: w = {2{d[15:0]}};
            default:       w = d;
        endcase
        return w;
    endfunction

    function automatic data_t mem_rdata(mem_op_t op, logic [1:0] lane, data_t word);
        logic [7:0]  b;
        logic [15:0] h;
        data_t       r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_B:   r = {{24{b[7]}}, b};
            MEM_BU:  r = {24'h000000, b};
            MEM_H:   r = {{16{h[15]}}, h};
            MEM_HU:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic mem_misaligned(mem_op_t op, logic [1:0] lane);
        logic m;
        case (op)
            MEM_B, MEM_BU: m = 1'b0;
            MEM_H, MEM_HU: m = lane[0];
            default:       m = (lane != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rv_mem_stage_align.sv
// rv_mem_align: purely combinational lane logic for the data bus.
// Request side turns an access code + low address bits + store operand into
// byte enables and lane-replicated write data. Response side extracts and
// extends the addressed lane of a returned load word. The two sides have
// independent inputs so a new request can be formed in the same cycle an
// older load response is being extracted.
//
// Ports:
//   req_op, req_lane, st_data   request access code, addr[1:0], store operand
//   be, wdata                   byte enables and lane-shifted store data
//   rsp_op, rsp_lane, ld_word   response access code, addr[1:0], bus word
//   ld_data                     aligned, extended load result
module rv_mem_align
    import rvcpu_pkg::*;
(
    input  mem_op_t    req_op,
    input  logic [1:0] req_lane,
    input  data_t      st_data,
    output logic [3:0] be,
    output data_t      wdata,
    input  mem_op_t    rsp_op,
    input  logic [1:0] rsp_lane,
    input  data_t      ld_word,
    output data_t      ld_data
);

    assign be      = mem_be(req_op, req_lane);
    assign wdata   = mem_wdata(req_op, st_data);
    assign ld_data = mem_rdata(rsp_op, rsp_lane, ld_word);

endmodule

// File: rtl/rv_mem_stage.sv
// rv_mem_stage: memory pipeline stage. Accepts stage_ex_t words from execute,
// runs data-bus accesses (req/gnt address phase, rvalid load response) and
// emits one registered stage_mem_t pulse per instruction to writeback.
//
// Optional feature macro: RVCPU_MISALIGN_TRAP_EN. When defined, misaligned
// h/hu/w accesses never reach the bus; they complete after one cycle with
// mem_valid and the extra misalign output pulsing together, rd_valid=0.
//
// Handshake: a word moves from execute when ex_valid & ex_ready are both high
// at a rising clk edge; ex_valid may not depend on ex_ready. Writeback always
// accepts, so mem_valid is a one-cycle pulse. On the bus, dbus_req and all
// dbus_* request fields stay stable until the cycle dbus_gnt is high.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ex_valid/ex_i      incoming instruction, ex_ready accepts it
//   mem_valid/mem_o    registered result pulse for writeback
//   misalign           (macro only) misaligned-access pulse
//   dbus_*             data-bus initiator interface
//   dbg_state          current FSM state, for observation only
module rv_mem_stage
    import rvcpu_pkg::*;
#(
    parameter int Width           = 32,
    parameter int ALLOW_BACK2BACK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  stage_ex_t        ex_i,
    output logic             ex_ready,
    output logic             mem_valid,
    output stage_mem_t       mem_o,
`ifdef RVCPU_MISALIGN_TRAP_EN
    output logic             misalign,
`endif
    output logic             dbus_req,
    output logic             dbus_we,
    output logic [Width-1:0] dbus_addr,
    output logic [3:0]       dbus_be,
    output logic [Width-1:0] dbus_wdata,
    input  logic             dbus_gnt,
    input  logic             dbus_rvalid,
    input  logic [Width-1:0] dbus_rdata,
    output mem_state_t       dbg_state
);

    mem_state_t state_q, state_d;
    logic       dbus_req_q, dbus_req_d;
    logic       dbus_we_q, dbus_we_d;
    data_t      dbus_addr_q, dbus_addr_d;
    logic [3:0] dbus_be_q, dbus_be_d;
    data_t      dbus_wdata_q, dbus_wdata_d;
    mem_op_t    op_q, op_d;
    logic [1:0] lane_q, lane_d;
    logic [4:0] rd_q, rd_d;
    logic       rd_valid_q, rd_valid_d;
    logic       mem_valid_q, mem_valid_d;
    stage_mem_t mem_o_q, mem_o_d;
    // A result accepted in a completion cycle cannot share the next output
    // slot with the completing access, so it waits here for one cycle.
    logic       pend_q, pend_d;
    stage_mem_t pend_o_q, pend_o_d;

    mem_op_t    ex_op;
    logic       ex_store;
    logic       mis_acc;
    logic       imm;
    stage_mem_t imm_o;
    logic       done_st, done_ld;
    logic       accept;
    logic [3:0] al_be;
    data_t      al_wdata, al_ld_data;

    assign ex_op    = mem_op_t'(ex_i.op[2:0]);
    assign ex_store = ex_i.op[MEM_STORE_BIT];

`ifdef RVCPU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic pend_mis_q, pend_mis_d;
    assign mis_acc  = ex_i.is_mem && mem_misaligned(ex_op, ex_i.addr[1:0]);
    assign misalign = misalign_q;
`else
    assign mis_acc = 1'b0;
`endif

    rv_mem_align u_align (
        .req_op   (ex_op),
        .req_lane (ex_i.addr[1:0]),
        .st_data  (ex_i.data),
        .be       (al_be),
        .wdata    (al_wdata),
        .rsp_op   (op_q),
        .rsp_lane (lane_q),
        .ld_word  (dbus_rdata),
        .ld_data  (al_ld_data)
    );

    // Words that finish without touching the bus.
    assign imm           = !ex_i.is_mem || mis_acc;
    assign imm_o.rd      = ex_i.rd;
    assign imm_o.rd_valid = ex_i.is_mem ? 1'b0 : ex_i.rd_valid;
    assign imm_o.rd_data = ex_i.is_mem ? '0 : ex_i.data;

    assign done_st  = (state_q == REQ) && dbus_gnt && dbus_we_q;
    assign done_ld  = (state_q == WAIT) && dbus_rvalid;
    assign ex_ready = ((state_q == IDLE) && !pend_q) ||
                      ((ALLOW_BACK2BACK != 0) && (done_st || done_ld));
    assign accept   = ex_valid && ex_ready;

    always_comb begin
        state_d      = state_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_be_d    = dbus_be_q;
        dbus_wdata_d = dbus_wdata_q;
        op_d         = op_q;
        lane_d       = lane_q;
        rd_d         = rd_q;
        rd_valid_d   = rd_valid_q;
        mem_valid_d  = 1'b0;
        mem_o_d      = mem_o_q;
        pend_d       = pend_q;
        pend_o_d     = pend_o_q;
`ifdef RVCPU_MISALIGN_TRAP_EN
        misalign_d   = 1'b0;
        pend_mis_d   = pend_mis_q;
`endif

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    mem_valid_d = 1'b1;
                    mem_o_d     = pend_o_q;
                    pend_d      = 1'b0;
`ifdef RVCPU_MISALIGN_TRAP_EN
                    misalign_d  = pend_mis_q;
`endif
                end
            end
            REQ: begin
                if (dbus_gnt) begin
                    dbus_req_d = 1'b0;
                    if (dbus_we_q) begin
                        mem_valid_d = 1'b1;
                        mem_o_d     = '{rd: rd_q, rd_valid: 1'b0, rd_data: '0};
                        state_d     = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dbus_rvalid) begin
                    mem_valid_d = 1'b1;
                    mem_o_d     = '{rd: rd_q, rd_valid: rd_valid_q, rd_data: al_ld_data};
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (imm) begin
                if (state_q == IDLE) begin
                    mem_valid_d = 1'b1;
                    mem_o_d     = imm_o;
`ifdef RVCPU_MISALIGN_TRAP_EN
                    misalign_d  = mis_acc;
`endif
                end else begin
                    pend_d   = 1'b1;
                    pend_o_d = imm_o;
`ifdef RVCPU_MISALIGN_TRAP_EN
                    pend_mis_d = mis_acc;
`endif
                end
            end else begin
                state_d      = REQ;
                dbus_req_d   = 1'b1;
                dbus_we_d    = ex_store;
                dbus_addr_d  = {ex_i.addr[31:2], 2'b00};
                dbus_be_d    = al_be;
                dbus_wdata_d = al_wdata;
                op_d         = ex_op;
                lane_d       = ex_i.addr[1:0];
                rd_d         = ex_i.rd;
                rd_valid_d   = ex_store ? 1'b0 : ex_i.rd_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_be_q    <= '0;
            dbus_wdata_q <= '0;
            op_q         <= MEM_B;
            lane_q       <= '0;
            rd_q         <= '0;
            rd_valid_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_o_q      <= '0;
            pend_q       <= 1'b0;
            pend_o_q     <= '0;
`ifdef RVCPU_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
            pend_mis_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_be_q    <= dbus_be_d;
            dbus_wdata_q <= dbus_wdata_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            rd_q         <= rd_d;
            rd_valid_q   <= rd_valid_d;
            mem_valid_q  <= mem_valid_d;
            mem_o_q      <= mem_o_d;
            pend_q       <= pend_d;
            pend_o_q     <= pend_o_d;
`ifdef RVCPU_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
            pend_mis_q   <= pend_mis_d;
`endif
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_o      = mem_o_q;
    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_be    = dbus_be_q;
    assign dbus_wdata = dbus_wdata_q;
    assign dbg_state  = state_q;

    // A load response is only legal once the address phase has been granted.
    a_no_rvalid_in_req: assert property (@(posedge clk) disable iff (rst)
        !((state_q == REQ) && dbus_rvalid));

endmodule

// File: tb/tb_rv_mem_stage.sv
module tb_rv_mem_stage;
    import rvcpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid;
    stage_ex_t  ex_i;
    logic       ex_ready;
    logic       mem_valid;
    stage_mem_t mem_o;
`ifdef RVCPU_MISALIGN_TRAP_EN
    logic       misalign;
`endif
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt, dbus_rvalid;
    mem_state_t  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [37:0] exp_q[$];

    rv_mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_i        (ex_i),
        .ex_ready    (ex_ready),
        .mem_valid   (mem_valid),
        .mem_o       (mem_o),
`ifdef RVCPU_MISALIGN_TRAP_EN
        .misalign    (misalign),
`endif
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_be     (dbus_be),
        .dbus_wdata  (dbus_wdata),
        .dbus_gnt    (dbus_gnt),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic stage_ex_t mk_ex(input logic m, input logic [3:0] op, input logic [4:0] rd,
                                        input logic rv, input logic [31:0] a, input logic [31:0] d);
        stage_ex_t e;
        e.is_mem = m; e.op = op; e.rd = rd; e.rd_valid = rv; e.addr = a; e.data = d;
        return e;
    endfunction

    function automatic logic [37:0] mk_mem(input logic [4:0] rd, input logic rv, input logic [31:0] d);
        return {rd, rv, d};
    endfunction

    // reference load extraction
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] sh;
        sh = w >> (8 * a);
        b  = sh[7:0];
        h  = (a >= 2) ? w[31:16] : w[15:0];
        if (op == 3'b000) return {{24{b[7]}}, b};
        if (op == 3'b100) return {24'd0, b};
        if (op == 3'b001) return {{16{h[15]}}, h};
        if (op == 3'b101) return {16'd0, h};
        return w;
    endfunction

    // scoreboard: every mem_valid pulse pops one expected result
    always @(negedge clk) begin
        if (!rst && mem_valid) begin
            check("mem_q_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("mem_o", 64'(mem_o), 64'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic send(input stage_ex_t e);
        int n;
        n = 0;
        ex_i = e;
        ex_valid = 1'b1;
        @(negedge clk);
        while (!ex_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'(ex_ready), 64'(1));
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic do_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd, input int stalls,
                            input logic [4:0] rd);
        exp_q.push_back(mk_mem(rd, 1'b0, 32'd0));
        send(mk_ex(1'b1, op, rd, 1'b1, a, d));
        for (int i = 0; i <= stalls; i++) begin
            if (i == stalls) dbus_gnt = 1'b1;
            @(negedge clk);
            check("st_req", 64'(dbus_req), 64'(1));
            check("st_we", 64'(dbus_we), 64'(1));
            check("st_addr", 64'(dbus_addr), 64'(a & 32'hFFFF_FFFC));
            check("st_be", 64'(dbus_be), 64'(exp_be));
            check("st_wdata", 64'(dbus_wdata), 64'(exp_wd));
            @(posedge clk); #1;
        end
        dbus_gnt = 1'b0;
        @(negedge clk);
        check("st_req_drop", 64'(dbus_req), 64'(0));
        check("st_mem_valid", 64'(mem_valid), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] word,
                           input logic [4:0] rd, input logic [31:0] exp_d, input int gst, input int rst_w);
        exp_q.push_back(mk_mem(rd, 1'b1, exp_d));
        send(mk_ex(1'b1, op, rd, 1'b1, a, 32'h5A5A_5A5A));
        for (int i = 0; i <= gst; i++) begin
            if (i == gst) dbus_gnt = 1'b1;
            @(negedge clk);
            check("ld_req", 64'(dbus_req), 64'(1));
            check("ld_we", 64'(dbus_we), 64'(0));
            check("ld_addr", 64'(dbus_addr), 64'(a & 32'hFFFF_FFFC));
            @(posedge clk); #1;
        end
        dbus_gnt = 1'b0;
        for (int i = 0; i <= rst_w; i++) begin
            if (i == rst_w) begin
                dbus_rvalid = 1'b1;
                dbus_rdata  = word;
            end
            @(negedge clk);
            check("ld_req_low", 64'(dbus_req), 64'(0));
            check("ld_no_early", 64'(mem_valid), 64'(0));
            @(posedge clk); #1;
        end
        dbus_rvalid = 1'b0;
        dbus_rdata  = $urandom;
        @(negedge clk);
        check("ld_mem_valid", 64'(mem_valid), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [1:0]  rlane;
        logic [31:0] rword;
        logic [2:0]  ops [5];
        ops[0] = 3'b000; ops[1] = 3'b100; ops[2] = 3'b001; ops[3] = 3'b101; ops[4] = 3'b011;

        rst = 1'b1; ex_valid = 1'b0; ex_i = '0;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_mem_o", 64'(mem_o), 64'(0));
        check("rst_req", 64'(dbus_req), 64'(0));
        check("rst_we", 64'(dbus_we), 64'(0));
        check("rst_addr", 64'(dbus_addr), 64'(0));
        check("rst_be", 64'(dbus_be), 64'(0));
        check("rst_wdata", 64'(dbus_wdata), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_ready", 64'(ex_ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // non-memory pass-through
        exp_q.push_back(mk_mem(5'd5, 1'b1, 32'hDEAD_BEEF));
        send(mk_ex(1'b0, 4'b0000, 5'd5, 1'b1, 32'h0, 32'hDEAD_BEEF));
        @(negedge clk);
        check("nm_mem_valid", 64'(mem_valid), 64'(1));
        check("nm_no_req", 64'(dbus_req), 64'(0));
        @(posedge clk); #1;

        // stores
        do_store(4'b1000, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 2, 5'd7);
        do_store(4'b1001, 32'h0000_1002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 0, 5'd8);
        do_store(4'b1011, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1, 5'd9);

        // directed loads
        do_load(4'b0000, 32'h0000_2001, 32'h0000_8000, 5'd10, 32'hFFFF_FF80, 0, 0);
        do_load(4'b0100, 32'h0000_2001, 32'h0000_8000, 5'd11, 32'h0000_0080, 1, 2);
        do_load(4'b0101, 32'h0000_2002, 32'hBEEF_1234, 5'd12, 32'h0000_BEEF, 0, 1);
        do_load(4'b0001, 32'h0000_2002, 32'hBEEF_1234, 5'd13, 32'hFFFF_BEEF, 2, 0);
        do_load(4'b0110, 32'h0000_2004, 32'h1234_5678, 5'd14, 32'h1234_5678, 0, 0);

        // random aligned loads
        for (int k = 0; k < 8; k++) begin
            rop   = ops[$urandom_range(0, 4)];
            rword = $urandom;
            if (rop == 3'b000 || rop == 3'b100) rlane = 2'($urandom_range(0, 3));
            else if (rop == 3'b011) rlane = 2'b00;
            else rlane = {1'($urandom_range(0, 1)), 1'b0};
            do_load({1'b0, rop}, {28'h0000_300, 2'b00, rlane}, rword, 5'($urandom_range(1, 31)),
                    model_load(rop, rlane, rword), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // back-to-back: non-mem held while a load completes
        exp_q.push_back(mk_mem(5'd3, 1'b1, 32'h0000_00AA));
        exp_q.push_back(mk_mem(5'd9, 1'b1, 32'h0000_0055));
        send(mk_ex(1'b1, 4'b0100, 5'd3, 1'b1, 32'h0000_2003, 32'h0));
        dbus_gnt = 1'b1;
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        ex_i = mk_ex(1'b0, 4'b0000, 5'd9, 1'b1, 32'h0, 32'h0000_0055);
        ex_valid = 1'b1;
        @(negedge clk);
        check("b2b_ready_wait", 64'(ex_ready), 64'(0));
        @(posedge clk); #1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hAA00_0000;
        @(negedge clk);
        check("b2b_ready_done", 64'(ex_ready), 64'(1));
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        check("b2b_pulse1", 64'(mem_valid), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_pulse2", 64'(mem_valid), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_quiet", 64'(mem_valid), 64'(0));
        check("b2b_ready_idle", 64'(ex_ready), 64'(1));
        @(posedge clk); #1;

        // reset in WAIT, then a late rvalid
        send(mk_ex(1'b1, 4'b0100, 5'd4, 1'b1, 32'h0000_2000, 32'h0));
        dbus_gnt = 1'b1;
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        @(negedge clk);
        check("rw_state_wait", 64'(dbg_state), 64'(WAIT));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rw_req", 64'(dbus_req), 64'(0));
        check("rw_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h0000_00FF;
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        @(negedge clk);
        check("rw_late_ignored", 64'(mem_valid), 64'(0));
        check("rw_late_req", 64'(dbus_req), 64'(0));
        @(posedge clk); #1;
        do_load(4'b0000, 32'h0000_2000, 32'h0000_00FF, 5'd6, 32'hFFFF_FFFF, 0, 0);

`ifdef RVCPU_MISALIGN_TRAP_EN
        exp_q.push_back(mk_mem(5'd15, 1'b0, 32'h0));
        send(mk_ex(1'b1, 4'b0011, 5'd15, 1'b1, 32'h0000_3002, 32'h0));
        @(negedge clk);
        check("mis_flag", 64'(misalign), 64'(1));
        check("mis_valid", 64'(mem_valid), 64'(1));
        check("mis_no_req", 64'(dbus_req), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_flag_drop", 64'(misalign), 64'(0));
        check("mis_no_req2", 64'(dbus_req), 64'(0));
        @(posedge clk); #1;
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
